// File: rtl/clk_freq_meter_pkg.sv
// Shared types and constants for the clock frequency meter.
//   clk_freq_meter_state_e : FSM state encoding used by clk_freq_meter
//   warm_cycles()          : number of WARM cycles for a given synchronizer depth
package clk_freq_meter_pkg;

  typedef enum logic [1:0] {eWarm, eIdle, eCount, eDone} clk_freq_meter_state_e;

  // One extra cycle beyond the synchronizer depth also flushes the
  // previous-sample flop of the edge detector.
  localparam int unsigned warm_extra_lp = 1;

  function automatic int unsigned warm_cycles(input int unsigned sync_stages);
    return sync_stages + warm_extra_lp;
  endfunction

endpackage

// File: rtl/clk_freq_meter_sync.sv
// Synchronizer and rising-edge detector for the clock under test.
// Ports:
//   clk_i    in   system clock
//   reset_i  in   asynchronous active-high reset
//   async_i  in   signal asynchronous to clk_i
//   edge_o   out  one-cycle pulse per synchronized rising edge of async_i
// The pipeline is free-running; it never stalls with the FSM state.
module clk_freq_meter_sync #(
  parameter int sync_stages_p = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic edge_o
);

  logic [sync_stages_p-1:0] sync_r;
  logic                     prev_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[sync_stages_p-2:0], async_i};
      prev_r <= sync_r[sync_stages_p-1];
    end
  end

  assign edge_o = sync_r[sync_stages_p-1] & ~prev_r;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of meas_clk_i over a programmable window of clk_i
// cycles and returns the result through a valid/yumi handshake.
// Ports:
//   clk_i       in   system/reference clock (only clock)
//   reset_i     in   asynchronous active-high reset
//   meas_clk_i  in   clock under test, asynchronous to clk_i
//   window_i    in   window length in clk_i cycles, sampled on accept
//   v_i         in   start request
//   ready_o     out  start request can be accepted
//   count_o     out  edges counted in the window (saturating)
//   overflow_o  out  count saturated during the window
//   v_o         out  count_o/overflow_o valid
//   yumi_i      in   consumer takes the result
//
// state  | meaning
// eWarm  | after reset, flush the synchronizer before accepting work
// eIdle  | ready_o=1, waiting for v_i
// eCount | window running, edges accumulated each cycle
// eDone  | v_o=1, result held until yumi_i
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int window_width_p = 16,
  parameter int count_width_p  = 16,
  parameter int sync_stages_p  = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      meas_clk_i,
  input  logic [window_width_p-1:0] window_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [count_width_p-1:0]  count_o,
  output logic                      overflow_o,
  output logic                      v_o,
  input  logic                      yumi_i
);

  localparam int unsigned warm_cycles_lp = warm_cycles(sync_stages_p);
  localparam int          warm_w_lp      = $clog2(warm_cycles_lp + 1);

  clk_freq_meter_state_e     state_r, state_n;
  logic [warm_w_lp-1:0]      warm_cnt_r;
  logic [window_width_p-1:0] down_r;
  logic [count_width_p-1:0]  count_r;
  logic                      overflow_r;
  logic                      meas_edge;
  logic                      accept;
  logic                      warm_done;

  clk_freq_meter_sync #(
    .sync_stages_p(sync_stages_p)
  ) sync_u (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .async_i(meas_clk_i),
    .edge_o (meas_edge)
  );

  assign accept    = (state_r == eIdle) & v_i;
  assign warm_done = (warm_cnt_r == warm_w_lp'(warm_cycles_lp - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= eWarm;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      eWarm:  if (warm_done) state_n = eIdle;
      eIdle:  if (v_i) state_n = (window_i == '0) ? eDone : eCount;
      eCount: if (down_r == window_width_p'(1)) state_n = eDone;
      eDone:  if (yumi_i) state_n = eIdle;
      default: state_n = eWarm;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      warm_cnt_r <= '0;
      down_r     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (state_r == eWarm) warm_cnt_r <= warm_cnt_r + 1'b1;

      if (accept)                  down_r <= window_i;
      else if (state_r == eCount)  down_r <= down_r - 1'b1;

      // The accept cycle's edge is deliberately dropped: the count only
      // covers the window_i cycles spent in eCount.
      if (accept) begin
        count_r    <= '0;
        overflow_r <= 1'b0;
      end else if ((state_r == eCount) && meas_edge) begin
        if (&count_r) overflow_r <= 1'b1;
        else          count_r    <= count_r + 1'b1;
      end
    end
  end

  assign ready_o    = (state_r == eIdle);
  assign v_o        = (state_r == eDone);
  assign count_o    = count_r;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_clk_freq_meter.sv
module tb_clk_freq_meter;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        meas_clk = 1'b0;
  logic [15:0] window = '0;
  logic        v = 1'b0;
  logic        yumi = 1'b0;
  logic        sel = 1'b0;

  int          meas_period = 0;
  logic        meas_level = 1'b0;
  int          ph = 0;

  logic        ready_a, ovf_a, vo_a;
  logic [15:0] count_a;
  logic        ready_b, ovf_b, vo_b;
  logic [3:0]  count_b;

  logic        ready, ovf_m, vo;
  logic [15:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  // Clock under test: changes 2 ns after clk_i falling edge, well away from
  // the rising edge. Period is in clk_i cycles; 0 means hold meas_level.
  always @(negedge clk_i) begin
    #2;
    if (meas_period == 0) begin
      meas_clk = meas_level;
    end else begin
      ph = (ph + 1) % meas_period;
      meas_clk = (ph < meas_period / 2);
    end
  end

  clk_freq_meter #(.window_width_p(16), .count_width_p(16), .sync_stages_p(2)) dut_a (
    .clk_i(clk_i), .reset_i(rst), .meas_clk_i(meas_clk), .window_i(window),
    .v_i(v & ~sel), .ready_o(ready_a), .count_o(count_a), .overflow_o(ovf_a),
    .v_o(vo_a), .yumi_i(yumi & ~sel)
  );

  clk_freq_meter #(.window_width_p(16), .count_width_p(4), .sync_stages_p(2)) dut_b (
    .clk_i(clk_i), .reset_i(rst), .meas_clk_i(meas_clk), .window_i(window),
    .v_i(v & sel), .ready_o(ready_b), .count_o(count_b), .overflow_o(ovf_b),
    .v_o(vo_b), .yumi_i(yumi & sel)
  );

  assign ready = sel ? ready_b : ready_a;
  assign ovf_m = sel ? ovf_b : ovf_a;
  assign vo    = sel ? vo_b : vo_a;
  assign count = sel ? {12'b0, count_b} : count_a;

  // Runs one measurement; lat = posedges from the accept edge (inclusive)
  // until v_o is seen, or -1 on timeout.
  task automatic do_measure(input logic [15:0] win, input logic take,
                            output int lat, output logic [15:0] cnt, output logic ov);
    int guard;
    guard = 0;
    @(negedge clk_i);
    while (ready !== 1'b1 && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
    window = win;
    v = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    v = 1'b0;
    lat = 1;
    while (vo !== 1'b1 && lat < int'(win) + 50) begin
      @(negedge clk_i);
      lat++;
    end
    if (vo !== 1'b1) lat = -1;
    cnt = count;
    ov = ovf_m;
    if (take) begin
      yumi = 1'b1;
      @(negedge clk_i);
      yumi = 1'b0;
    end
  endtask

  task automatic settle_meas(input int period, input logic level);
    meas_period = period;
    meas_level = level;
    repeat (8) @(negedge clk_i);
  endtask

  task automatic test_reset;
    int n;
    logic bad;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (ready !== 1'b0 || vo !== 1'b0 || count !== 16'd0 || ovf_m !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b v=%b count=%0d ovf=%b required all 0", ready, vo, count, ovf_m);
    end
    #1 rst = 1'b0;
    n = 0;
    bad = 1'b0;
    while (ready === 1'b0 && n < 20) begin
      if (vo !== 1'b0 || count !== 16'd0) bad = 1'b1;
      n++;
      @(negedge clk_i);
      #1;
    end
    n_checks++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL warm_length: ready low for %0d cycles, required 3", n);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL warm_outputs: v_o/count_o nonzero during WARM, required 0");
    end
  endtask

  task automatic test_count_periodic;
    int lat;
    logic [15:0] cnt;
    logic ov;
    settle_meas(10, 1'b0);
    do_measure(16'd100, 1'b1, lat, cnt, ov);
    n_checks++;
    if (lat !== 101) begin n_fail++; $display("FAIL latency_w100: got %0d required 101", lat); end
    n_checks++;
    if (!(cnt >= 16'd10 && cnt <= 16'd11)) begin n_fail++; $display("FAIL count_p10: got %0d required 10..11", cnt); end
    n_checks++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL ovf_p10: got %b required 0", ov); end

    settle_meas(4, 1'b0);
    do_measure(16'd1000, 1'b1, lat, cnt, ov);
    n_checks++;
    if (lat !== 1001) begin n_fail++; $display("FAIL latency_w1000: got %0d required 1001", lat); end
    n_checks++;
    if (!(cnt >= 16'd250 && cnt <= 16'd251)) begin n_fail++; $display("FAIL count_p4: got %0d required 250..251", cnt); end
  endtask

  task automatic test_static;
    int lat;
    logic [15:0] cnt;
    logic ov;
    for (int lvl = 0; lvl < 2; lvl++) begin
      settle_meas(0, lvl[0]);
      do_measure(16'd50, 1'b1, lat, cnt, ov);
      n_checks++;
      if (cnt !== 16'd0 || ov !== 1'b0) begin
        n_fail++;
        $display("FAIL static_level%0d: count=%0d ovf=%b required 0/0", lvl, cnt, ov);
      end
    end
  endtask

  task automatic test_saturation;
    int lat;
    logic [15:0] cnt;
    logic ov;
    sel = 1'b1;
    settle_meas(4, 1'b0);
    do_measure(16'd200, 1'b1, lat, cnt, ov);
    n_checks++;
    if (lat !== 201) begin n_fail++; $display("FAIL sat_latency: got %0d required 201", lat); end
    n_checks++;
    if (cnt !== 16'd15 || ov !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_count: count=%0d ovf=%b required 15/1", cnt, ov);
    end
    settle_meas(0, 1'b0);
    do_measure(16'd50, 1'b1, lat, cnt, ov);
    n_checks++;
    if (cnt !== 16'd0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_cleared: count=%0d ovf=%b required 0/0", cnt, ov);
    end
    sel = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_window_zero;
    int lat;
    logic [15:0] cnt;
    logic ov;
    settle_meas(10, 1'b0);
    do_measure(16'd0, 1'b0, lat, cnt, ov);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL w0_latency: got %0d required 1", lat); end
    n_checks++;
    if (cnt !== 16'd0 || ov !== 1'b0) begin n_fail++; $display("FAIL w0_count: count=%0d ovf=%b required 0/0", cnt, ov); end
    for (int i = 0; i < 5; i++) begin
      v = 1'b1;
      window = 16'd7;
      @(negedge clk_i);
      n_checks++;
      if (vo !== 1'b1 || ready !== 1'b0 || count !== 16'd0 || ovf_m !== 1'b0) begin
        n_fail++;
        $display("FAIL w0_hold%0d: v=%b ready=%b count=%0d ovf=%b required 1/0/0/0", i, vo, ready, count, ovf_m);
      end
    end
    v = 1'b0;
    yumi = 1'b1;
    @(negedge clk_i);
    yumi = 1'b0;
    n_checks++;
    if (vo !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL w0_yumi: v=%b ready=%b required 0/1", vo, ready);
    end
  endtask

  task automatic test_reset_mid_count;
    int lat;
    int n;
    logic [15:0] cnt;
    logic ov;
    settle_meas(10, 1'b0);
    while (ready !== 1'b1) @(negedge clk_i);
    window = 16'd100;
    v = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    v = 1'b0;
    repeat (39) @(negedge clk_i);
    n_checks++;
    if (!(count >= 16'd3 && count <= 16'd5) || vo !== 1'b0) begin
      n_fail++;
      $display("FAIL midcount_progress: count=%0d v=%b required 3..5/0", count, vo);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (vo !== 1'b0 || count !== 16'd0 || ovf_m !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midcount_async: v=%b count=%0d ovf=%b ready=%b required all 0", vo, count, ovf_m, ready);
    end
    @(negedge clk_i);
    #1 rst = 1'b0;
    n = 0;
    while (ready === 1'b0 && n < 20) begin
      n++;
      @(negedge clk_i);
      #1;
    end
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL midcount_warm: ready low for %0d cycles, required 3", n); end
    do_measure(16'd100, 1'b1, lat, cnt, ov);
    n_checks++;
    if (lat !== 101 || !(cnt >= 16'd10 && cnt <= 16'd11) || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL midcount_next: lat=%0d count=%0d ovf=%b required 101/10..11/0", lat, cnt, ov);
    end
  endtask

  initial begin
    test_reset();
    test_count_periodic();
    test_static();
    test_saturation();
    test_window_zero();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
